// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM initiator for the 1024x32 on-chip memory: block copy or constant
// fill, with a completion pulse, a word count and a running checksum.
module onchip_mem_copy_master #(
   parameter int READ_LATENCY = 1,
   parameter int ADDR_W       = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W:0]   len,
   input  logic [31:0]       fill_value,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [ADDR_W:0]   words_done,
   output logic [31:0]       checksum,
   output logic [ADDR_W-1:0] address,
   output logic              chipselect,
   output logic              write,
   output logic [31:0]       writedata,
   output logic [3:0]        byteenable,
   output logic              clken,
   input  logic [31:0]       readdata
);

   typedef enum logic [2:0] {IDLE, RD, LAT, WR, FIN} state_t;

   localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

   state_t            state;
   logic              mode_r;
   logic [ADDR_W:0]   len_r;
   logic [31:0]       fill_r;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [2:0]        lat_cnt;
   logic              abort_flag;

   logic [ADDR_W-1:0] src_inc;
   logic [ADDR_W-1:0] dst_inc;
   logic [ADDR_W:0]   words_inc;

   // Full-width byte lanes and an always-on clock enable
   assign byteenable = 4'hF;
   assign clken      = 1'b1;

   // Next-word pointers wrap naturally at the top of the address space
   assign src_inc   = src_ptr + 1'b1;
   assign dst_inc   = dst_ptr + 1'b1;
   assign words_inc = words_done + 1'b1;

   // Job FSM; bus strobes and status are registered on the transition into each state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         mode_r     <= 1'b0;
         len_r      <= '0;
         fill_r     <= '0;
         src_ptr    <= '0;
         dst_ptr    <= '0;
         lat_cnt    <= '0;
         abort_flag <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         words_done <= '0;
         checksum   <= '0;
         address    <= '0;
         chipselect <= 1'b0;
         write      <= 1'b0;
         writedata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done    <= 1'b0;
               aborted <= 1'b0;
               if (start) begin
                  mode_r     <= mode;
                  len_r      <= len;
                  fill_r     <= fill_value;
                  src_ptr    <= src;
                  dst_ptr    <= dst;
                  words_done <= '0;
                  checksum   <= '0;
                  abort_flag <= 1'b0;
                  busy       <= 1'b1;
                  if (len == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else if (mode) begin
                     state      <= WR;
                     chipselect <= 1'b1;
                     write      <= 1'b1;
                     address    <= dst;
                     writedata  <= fill_value;
                  end else begin
                     state      <= RD;
                     chipselect <= 1'b1;
                     write      <= 1'b0;
                     address    <= src;
                  end
               end
            end
            RD: begin
               chipselect <= 1'b0;
               lat_cnt    <= LAT_LAST;
               abort_flag <= abort_flag | abort;
               state      <= LAT;
            end
            LAT: begin
               abort_flag <= abort_flag | abort;
               if (lat_cnt == '0) begin
                  writedata  <= readdata;
                  chipselect <= 1'b1;
                  write      <= 1'b1;
                  address    <= dst_ptr;
                  state      <= WR;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            WR: begin
               words_done <= words_inc;
               checksum   <= checksum + writedata;
               src_ptr    <= src_inc;
               dst_ptr    <= dst_inc;
               if (words_inc == len_r || abort || abort_flag) begin
                  state      <= FIN;
                  chipselect <= 1'b0;
                  write      <= 1'b0;
                  done       <= 1'b1;
                  aborted    <= abort | abort_flag;
               end else if (mode_r) begin
                  address   <= dst_inc;
                  writedata <= fill_r;
               end else begin
                  state   <= RD;
                  write   <= 1'b0;
                  address <= src_inc;
               end
            end
            FIN: begin
               done    <= 1'b0;
               aborted <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Self-checking bench for onchip_mem_copy_master with a behavioural 1024x32
// memory (read latency 1) and a write scoreboard.
module tb_onchip_mem_copy_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [9:0]  src = '0;
   logic [9:0]  dst = '0;
   logic [10:0] len = '0;
   logic [31:0] fill_value = '0;
   logic        abort = 1'b0;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [10:0] words_done;
   logic [31:0] checksum;
   logic [9:0]  address;
   logic        chipselect;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        clken;
   logic [31:0] readdata = '0;

   typedef struct packed {
      logic [9:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         sb[$];
   logic [31:0] mem [0:1023];
   logic        pre_we = 1'b0;
   logic [9:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          cs_count = 0;
   logic [31:0] exp_sum = '0;
   int          vectors = 0;
   int          miscompares = 0;

   onchip_mem_copy_master #(.READ_LATENCY(1), .ADDR_W(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mode       (mode),
      .src        (src),
      .dst        (dst),
      .len        (len),
      .fill_value (fill_value),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .words_done (words_done),
      .checksum   (checksum),
      .address    (address),
      .chipselect (chipselect),
      .write      (write),
      .writedata  (writedata),
      .byteenable (byteenable),
      .clken      (clken),
      .readdata   (readdata)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Cycle counter for latency measurements
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: latency-1 reads, plus a side door for preloading
   always @(posedge clk) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (chipselect && write)
         mem[address] <= writedata;
      if (chipselect && !write)
         readdata <= mem[address];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
      end
   endtask

   // Bus monitor: every write cycle must match the head of the scoreboard
   always @(negedge clk) begin
      wr_t e;
      if (!reset && chipselect) cs_count++;
      if (!reset && chipselect && write) begin
         checkOutput("wr_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("wr_addr", 32'(address), 32'(e.a));
            checkOutput("wr_data", writedata, e.d);
         end
      end
   end

   task automatic preloadWord(input logic [9:0] a, input logic [31:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   // Strobe start for one cycle and queue the writes the job should make
   task automatic applyStimulus(input logic m, input logic [9:0] s, input logic [9:0] d,
                                input logic [10:0] l, input logic [31:0] fv,
                                input int n_words);
      wr_t e;
      mode       = m;
      src        = s;
      dst        = d;
      len        = l;
      fill_value = fv;
      start      = 1'b1;
      start_cyc  = cyc;
      cs_count   = 0;
      exp_sum    = '0;
      for (int i = 0; i < n_words; i++) begin
         e.a = d + 10'(i);
         e.d = m ? fv : mem[s + 10'(i)];
         sb.push_back(e);
         exp_sum = exp_sum + e.d;
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_rise", 32'(busy), 32'd1);
   endtask

   // Wait (bounded) for done and check latency and job results
   task automatic waitDone(input string tag, input int exp_cycles, input int exp_words,
                           input logic exp_aborted);
      int waited = 0;
      while (done !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
      checkOutput({tag, "_cycles"}, 32'(cyc - start_cyc), 32'(exp_cycles));
      checkOutput({tag, "_aborted"}, 32'(aborted), 32'(exp_aborted));
      checkOutput({tag, "_words"}, 32'(words_done), 32'(exp_words));
      checkOutput({tag, "_checksum"}, checksum, exp_sum);
      checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      @(negedge clk);
      checkOutput({tag, "_busy_fall"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_sum_hold"}, checksum, exp_sum);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_cs", 32'(chipselect), 32'd0);
      checkOutput("rst_wr", 32'(write), 32'd0);
      checkOutput("rst_be", 32'(byteenable), 32'hF);
      checkOutput("rst_clken", 32'(clken), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // Fill 4 words at 0x100
      applyStimulus(1'b1, 10'h000, 10'h100, 11'd4, 32'hA5A5A5A5, 4);
      waitDone("fill", 5, 4, 1'b0);
      checkOutput("fill_sum_const", exp_sum, 32'h96969694);

      // Copy 3 words 0x000 -> 0x200
      preloadWord(10'h000, 32'd1);
      preloadWord(10'h001, 32'd2);
      preloadWord(10'h002, 32'd3);
      applyStimulus(1'b0, 10'h000, 10'h200, 11'd3, 32'h0, 3);
      waitDone("copy", 10, 3, 1'b0);
      checkOutput("copy_sum_const", checksum, 32'd6);
      for (int i = 0; i < 3; i++)
         checkOutput("copy_mem", mem[10'h200 + 10'(i)], 32'(i + 1));

      // Fill across the top of the address space
      preloadWord(10'h002, 32'h0000DEAD);
      applyStimulus(1'b1, 10'h000, 10'h3FE, 11'd4, 32'd7, 4);
      waitDone("wrap", 5, 4, 1'b0);
      checkOutput("wrap_mem0", mem[0], 32'd7);
      checkOutput("wrap_mem2", mem[2], 32'h0000DEAD);

      // Zero-length job: no bus activity
      applyStimulus(1'b1, 10'h000, 10'h080, 11'd0, 32'h55, 0);
      waitDone("zero", 1, 0, 1'b0);
      checkOutput("zero_no_cs", 32'(cs_count), 32'd0);

      // Second start while busy must be ignored
      applyStimulus(1'b1, 10'h000, 10'h140, 11'd4, 32'h0BADF00D, 4);
      mode       = 1'b0;
      dst        = 10'h300;
      len        = 11'd1;
      fill_value = 32'h11111111;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone("ignore", 5, 4, 1'b0);

      // Abort during the third word's latency cycle
      for (int i = 0; i < 10; i++)
         preloadWord(10'h010 + 10'(i), 32'h100 + 32'(i));
      applyStimulus(1'b0, 10'h010, 10'h220, 11'd10, 32'h0, 3);
      repeat (7) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      waitDone("abort", 10, 3, 1'b1);

      // Reset in the middle of a fill
      applyStimulus(1'b1, 10'h000, 10'h040, 11'd8, 32'h12345678, 8);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("mrst_cs", 32'(chipselect), 32'd0);
      checkOutput("mrst_wr", 32'(write), 32'd0);
      checkOutput("mrst_busy", 32'(busy), 32'd0);
      checkOutput("mrst_words", 32'(words_done), 32'd0);
      checkOutput("mrst_sum", checksum, 32'd0);
      checkOutput("mrst_addr", 32'(address), 32'd0);
      checkOutput("mrst_wdata", writedata, 32'd0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("mrst_no_done", 32'(done), 32'd0);
      applyStimulus(1'b1, 10'h000, 10'h050, 11'd2, 32'd5, 2);
      waitDone("post_rst", 3, 2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/onchip_mem_copy_master.md
# onchip_mem_copy_master

Avalon-MM initiator that drives the single-port 1024×32 on-chip memory slave (10-bit word address, 4-bit byteenable, read latency 1, no waitrequest). On command it either copies a block of words from one memory region to another or fills a region with a constant, and it reports completion and a running checksum. It sits between the control logic and the memory's s1/s2 port, owning `address`/`chipselect`/`write`/`writedata`/`byteenable`/`clken` for the duration of a job.

## Interface
- `READ_LATENCY`, 1: slave read latency in cycles (1..4); `readdata` is valid exactly this many cycles after the read cycle.
- `ADDR_W`, 10: word-address width; the address space is 2^ADDR_W words.
- `clk` in 1: single clock; all logic rises on it.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: one-cycle command strobe; ignored while `busy`=1.
- `mode` in 1: sampled with `start`; 0 = copy, 1 = fill.
- `src` in ADDR_W: copy source start word address, sampled with `start`.
- `dst` in ADDR_W: destination start word address, sampled with `start`.
- `len` in ADDR_W+1: word count 0..1024, sampled with `start`.
- `fill_value` in 32: fill word, sampled with `start`.
- `abort` in 1: level; stops the job at the next word boundary.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.
- `aborted` out 1: valid with `done`; 1 if the job ended by abort.
- `words_done` out ADDR_W+1: count of words written in the current or last job.
- `checksum` out 32: sum mod 2^32 of all words written in the current or last job.
- `address` out ADDR_W: to memory.
- `chipselect` out 1: to memory.
- `write` out 1: to memory.
- `writedata` out 32: to memory.
- `byteenable` out 4: to memory; constant 4'hF.
- `clken` out 1: to memory; constant 1 outside reset.
- `readdata` in 32: from memory.

## Operation
- FSM states: IDLE, RD, LAT, WR, FIN.
- IDLE: `start`=1 latches `mode`/`src`/`dst`/`len`/`fill_value`, clears `words_done` and `checksum`, and sets `busy`. Next state is FIN if `len`=0, else RD (copy) or WR (fill).
- RD: one cycle with `chipselect`=1, `write`=0, `address`=src_ptr. Next state is LAT.
- LAT: exactly READ_LATENCY cycles, bus idle (`chipselect`=0). On the final LAT cycle `readdata` is captured into the data register. Next state is WR.
- WR: one cycle with `chipselect`=1, `write`=1, `address`=dst_ptr, `writedata` = data register (copy) or `fill_value` (fill).
  - At the end of the cycle: `words_done`+=1, `checksum`+=writedata, src_ptr+=1, dst_ptr+=1 (both mod 2^ADDR_W, so 1023→0).
  - Next state is FIN if `words_done`+1 == len or `abort`=1; else RD (copy) or WR (fill).
- FIN: one cycle with `done`=1 and `aborted` = abort-taken flag. Next state is IDLE, where `busy` drops.
- Abort
  - `abort` is sampled only in WR, so the word in flight always completes its write.
  - In RD/LAT, `abort` is remembered in a sticky flag and acted on at the end of that word's WR.
  - The flag clears on `start`.
- Ordering: copy is strictly ascending. Overlapping regions with dst>src therefore propagate already-copied words; this is the defined behaviour.
- `start` during `busy`: ignored, no latch, no effect.
- `start` in the same cycle as FIN: ignored, because `busy` is still 1.
- `words_done` and `checksum` hold their final values after FIN until the next accepted `start`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `aborted`, `chipselect`, `write` = 0; `address`, `writedata`, `words_done`, `checksum` = 0; `byteenable`=4'hF; `clken`=1.
- All outputs are registered, or decoded from registered state only.
- Copy takes 2+READ_LATENCY cycles per word: 3 at the default.
- Fill takes 1 cycle per word, back-to-back writes.
- `busy` rises the cycle after `start` and falls the cycle after the `done` pulse.
- Total from `start` to the `done` pulse:
  - copy: len·(2+READ_LATENCY)+1 cycles;
  - fill: len+1 cycles;
  - `len`=0: 1 cycle, with no bus activity.
- `reset` mid-job: bus strobes deassert immediately (asynchronously). No `done` pulse is generated. A partially written region is left as-is.

## Test plan
- Fill: mode=1, dst=0x100, len=4, fill_value=0xA5A5A5A5 → 4 consecutive write cycles at 0x100..0x103; `done` 5 cycles after `start`; checksum=0x96969694; words_done=4.
- Copy: preload 0x000..0x002 with 1,2,3; src=0, dst=0x200, len=3 → memory 0x200..0x202 = 1,2,3; `done` 10 cycles after `start`; checksum=6.
- Wrap-around: fill with dst=0x3FE, len=4, value 7 → writes at 0x3FE, 0x3FF, 0x000, 0x001; nothing is written at 0x002.
- Zero length and ignored start: `len`=0 → `done` 1 cycle after `start` with no chipselect. A second `start` issued while `busy` changes neither the latched len nor the cycle count.
- Abort: copy with len=10; assert `abort` during the 3rd word's LAT → exactly 3 words are written; `done`=1 with `aborted`=1; words_done=3.
- Reset mid-job: assert `reset` during a fill's WR → `chipselect`/`write` drop within the same cycle, all outputs return to their reset values, and a new job afterwards runs normally.
